bridge_traffic_sequencer: RTL and testbench

Road-side sequencer for the drawbridge: it owns the traffic lights, the road barriers and the raise/lower requests sent to the drawbridge motor controller. A boat request walks the road through green → yellow → red → bridge-clear check → barriers down → lift → open. The sequence then runs lower → barriers up → green. Cycle-count timers enforce minimum green, yellow duration, clear-hold and barrier travel. The block sits between the operator/boat sensors and the drawbridge FSM.

---
 rtl/bridge_traffic_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_bridge_traffic_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bridge_traffic_sequencer.sv
// Road-side drawbridge sequencer: lights, barriers and lift/lower requests. Optional lift/lower watchdog via BRIDGE_SEQ_WATCHDOG_EN.
// States: 0 GREEN road open | 1 YELLOW warn | 2 CLEAR wait deck empty | 3 GATE_DN | 4 LIFT | 5 OPEN | 6 LOWER | 7 GATE_UP | 8 FAULT latched
module bridge_traffic_sequencer #(
    parameter int MIN_GREEN_CYC = 32,
    parameter int YELLOW_CYC    = 8,
    parameter int CLEAR_CYC     = 4,
    parameter int GATE_CYC      = 6,
    parameter int MOVE_TMO_CYC  = 200,
    parameter int CNT_W         = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       boat_req,
    input  logic       cars_on_bridge,
    input  logic       bridge_up,
    input  logic       bridge_down,
    output logic       light_green,
    output logic       light_yellow,
    output logic       light_red,
    output logic       gate_close,
    output logic       lift_req,
    output logic       lower_req,
    output logic       boat_go,
    output logic       alarm,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_GREEN   = 4'd0,
        ST_YELLOW  = 4'd1,
        ST_CLEAR   = 4'd2,
        ST_GATE_DN = 4'd3,
        ST_LIFT    = 4'd4,
        ST_OPEN    = 4'd5,
        ST_LOWER   = 4'd6,
        ST_GATE_UP = 4'd7,
        ST_FAULT   = 4'd8
    } state_t;

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    generate
        if (CNT_W < 1 || CNT_W > 30 ||
            MIN_GREEN_CYC < 1 || MIN_GREEN_CYC > CNT_MAX ||
            YELLOW_CYC    < 1 || YELLOW_CYC    > CNT_MAX ||
            CLEAR_CYC     < 1 || CLEAR_CYC     > CNT_MAX ||
            GATE_CYC      < 1 || GATE_CYC      > CNT_MAX ||
            MOVE_TMO_CYC  < 1 || MOVE_TMO_CYC  > CNT_MAX) begin : g_bad_cfg
            $error("bridge_traffic_sequencer: cycle parameter outside 1..2^CNT_W-1");
        end
    endgenerate

    // Each duration of N cycles ends on the cycle where the timer shows N-1.
    localparam logic [CNT_W-1:0] GREEN_SAT   = CNT_W'(MIN_GREEN_CYC);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
`ifdef BRIDGE_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] MOVE_LAST   = CNT_W'(MOVE_TMO_CYC - 1);
`endif

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_in_state;
    logic [CNT_W-1:0] timer_nxt;
    logic             green_nxt;
    logic             yellow_nxt;
    logic             red_nxt;
    logic             gate_nxt;
    logic             lift_nxt;
    logic             lower_nxt;
    logic             boat_go_nxt;
    logic             alarm_nxt;
    logic             deck_busy;

    always_comb begin
        nxt_state      = cur_state;
        timer_in_state = timer;

        case (cur_state)
            ST_GREEN: begin
                if (timer < GREEN_SAT) timer_in_state = timer + 1'b1;
                if (boat_req && timer >= GREEN_LAST) nxt_state = ST_YELLOW;
            end
            ST_YELLOW: begin
                timer_in_state = timer + 1'b1;
                if (timer == YELLOW_LAST) nxt_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (cars_on_bridge) begin
                    timer_in_state = '0;
                end else begin
                    timer_in_state = timer + 1'b1;
                    if (timer == CLEAR_LAST) nxt_state = ST_GATE_DN;
                end
            end
            ST_GATE_DN: begin
                timer_in_state = timer + 1'b1;
                if (timer == GATE_LAST) nxt_state = ST_LIFT;
            end
            ST_LIFT: begin
`ifdef BRIDGE_SEQ_WATCHDOG_EN
                // Paused lifts (car on deck) do not consume watchdog budget.
                if (lift_req) begin
                    timer_in_state = timer + 1'b1;
                    if (timer == MOVE_LAST) nxt_state = ST_FAULT;
                end
`endif
                if (bridge_up) nxt_state = ST_OPEN;
            end
            ST_OPEN: begin
                if (!boat_req) nxt_state = ST_LOWER;
            end
            ST_LOWER: begin
`ifdef BRIDGE_SEQ_WATCHDOG_EN
                timer_in_state = timer + 1'b1;
                if (timer == MOVE_LAST) nxt_state = ST_FAULT;
`endif
                if (bridge_down) nxt_state = ST_GATE_UP;
            end
            ST_GATE_UP: begin
                timer_in_state = timer + 1'b1;
                if (timer == GATE_LAST) nxt_state = ST_GREEN;
            end
            ST_FAULT: begin
                nxt_state = ST_FAULT;
            end
            default: begin
                nxt_state = ST_FAULT;
            end
        endcase

        // Contradictory limit switches override every other transition.
        if (bridge_up && bridge_down) nxt_state = ST_FAULT;

        timer_nxt = (nxt_state != cur_state) ? '0 : timer_in_state;

        deck_busy   = (nxt_state == ST_LIFT) || (nxt_state == ST_OPEN) ||
                      (nxt_state == ST_LOWER);
        green_nxt   = (nxt_state == ST_GREEN);
        yellow_nxt  = (nxt_state == ST_YELLOW);
        red_nxt     = !green_nxt && !yellow_nxt;
        gate_nxt    = deck_busy || (nxt_state == ST_GATE_DN) || (nxt_state == ST_FAULT);
        lift_nxt    = (nxt_state == ST_LIFT) && !cars_on_bridge;
        lower_nxt   = (nxt_state == ST_LOWER);
        boat_go_nxt = (nxt_state == ST_OPEN) && boat_req;
        alarm_nxt   = (nxt_state == ST_FAULT) || (deck_busy && cars_on_bridge);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cur_state    <= ST_GREEN;
            timer        <= '0;
            light_green  <= 1'b1;
            light_yellow <= 1'b0;
            light_red    <= 1'b0;
            gate_close   <= 1'b0;
            lift_req     <= 1'b0;
            lower_req    <= 1'b0;
            boat_go      <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            timer        <= timer_nxt;
            light_green  <= green_nxt;
            light_yellow <= yellow_nxt;
            light_red    <= red_nxt;
            gate_close   <= gate_nxt;
            lift_req     <= lift_nxt;
            lower_req    <= lower_nxt;
            boat_go      <= boat_go_nxt;
            alarm        <= alarm_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_bridge_traffic_sequencer.sv
// Directed bench for bridge_traffic_sequencer: full raise/lower cycle, car hold-off, sensor fault and async reset.
module tb_bridge_traffic_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       boat_req = 1'b0;
    logic       cars_on_bridge = 1'b0;
    logic       bridge_up = 1'b0;
    logic       bridge_down = 1'b0;
    logic       light_green, light_yellow, light_red, gate_close;
    logic       lift_req, lower_req, boat_go, alarm;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Output vector order: {green, yellow, red, gate, lift, lower, boat_go, alarm}
    localparam logic [7:0] O_GREEN   = 8'b1000_0000;
    localparam logic [7:0] O_YELLOW  = 8'b0100_0000;
    localparam logic [7:0] O_CLEAR   = 8'b0010_0000;
    localparam logic [7:0] O_GATE_DN = 8'b0011_0000;
    localparam logic [7:0] O_LIFT    = 8'b0011_1000;
    localparam logic [7:0] O_LIFT_HOLD = 8'b0011_0001;
    localparam logic [7:0] O_OPEN_GO = 8'b0011_0010;
    localparam logic [7:0] O_OPEN_NO = 8'b0011_0000;
    localparam logic [7:0] O_LOWER   = 8'b0011_0100;
    localparam logic [7:0] O_GATE_UP = 8'b0010_0000;
    localparam logic [7:0] O_FAULT   = 8'b0011_0001;

    bridge_traffic_sequencer dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .boat_req       (boat_req),
        .cars_on_bridge (cars_on_bridge),
        .bridge_up      (bridge_up),
        .bridge_down    (bridge_down),
        .light_green    (light_green),
        .light_yellow   (light_yellow),
        .light_red      (light_red),
        .gate_close     (gate_close),
        .lift_req       (lift_req),
        .lower_req      (lower_req),
        .boat_go        (boat_go),
        .alarm          (alarm),
        .state          (state)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_state, input logic [7:0] exp_out);
        logic [11:0] obs;
        logic [11:0] exp;
        obs = {state, light_green, light_yellow, light_red, gate_close,
               lift_req, lower_req, boat_go, alarm};
        exp = {exp_state, exp_out};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed state/outs=%03h expected=%03h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        // reset held, then synchronous release; boat waiting from cycle 0
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_hold", 4'd0, O_GREEN);
        Reset = 1'b1;
        boat_req = 1'b1;
        cyc = 0;
        chk("cyc0_green", 4'd0, O_GREEN);
        wait_to(31);  chk("green_last", 4'd0, O_GREEN);
        wait_to(32);  chk("yellow_first", 4'd1, O_YELLOW);
        wait_to(39);  chk("yellow_last", 4'd1, O_YELLOW);
        wait_to(40);  chk("clear_first", 4'd2, O_CLEAR);
        wait_to(43);  chk("clear_last", 4'd2, O_CLEAR);
        wait_to(44);  chk("gate_dn_first", 4'd3, O_GATE_DN);
        wait_to(49);  chk("gate_dn_last", 4'd3, O_GATE_DN);
        wait_to(50);  chk("lift_first", 4'd4, O_LIFT);

        // car on deck during lift: pause and alarm for 5 cycles
        wait_to(52);  cars_on_bridge = 1'b1;
        wait_to(53);  chk("lift_pause_a", 4'd4, O_LIFT_HOLD);
        wait_to(57);  chk("lift_pause_b", 4'd4, O_LIFT_HOLD);
        cars_on_bridge = 1'b0;
        wait_to(58);  chk("lift_resume", 4'd4, O_LIFT);

        wait_to(60);  bridge_up = 1'b1;
        wait_to(61);  chk("open_boat_go", 4'd5, O_OPEN_GO);
        wait_to(63);  boat_req = 1'b0;
        wait_to(64);  chk("lower", 4'd6, O_LOWER);
        bridge_up = 1'b0;
        wait_to(66);  bridge_down = 1'b1;
        wait_to(67);  chk("gate_up_first", 4'd7, O_GATE_UP);
        wait_to(72);  chk("gate_up_last", 4'd7, O_GATE_UP);
        wait_to(73);  chk("green_return", 4'd0, O_GREEN);

        // second request: car appears at clear-cycle 3, restarting the clear count
        boat_req = 1'b1;
        wait_to(104); chk("green2_last", 4'd0, O_GREEN);
        wait_to(105); chk("yellow2", 4'd1, O_YELLOW);
        wait_to(113); chk("clear2_first", 4'd2, O_CLEAR);
        wait_to(116); cars_on_bridge = 1'b1;
        wait_to(117); chk("clear_restart", 4'd2, O_CLEAR);
        cars_on_bridge = 1'b0;
        wait_to(120); chk("clear2_last", 4'd2, O_CLEAR);
        wait_to(121); chk("gate_dn2", 4'd3, O_GATE_DN);
        bridge_down = 1'b0;
        wait_to(127); chk("lift2", 4'd4, O_LIFT);

`ifdef BRIDGE_SEQ_WATCHDOG_EN
        wait_to(326); chk("wdog_before", 4'd4, O_LIFT);
        wait_to(327); chk("wdog_fault", 4'd8, O_FAULT);
        wait_to(1000); chk("wdog_stay", 4'd8, O_FAULT);
`else
        wait_to(1000); chk("lift_no_wdog", 4'd4, O_LIFT);
`endif

        // conflicting limit switches
        bridge_up = 1'b1;
        bridge_down = 1'b1;
        wait_to(1001); chk("conflict_fault", 4'd8, O_FAULT);
        bridge_up = 1'b0;
        bridge_down = 1'b0;
        wait_to(1006); chk("fault_latched", 4'd8, O_FAULT);

        // asynchronous assertion mid-cycle
        #2;
        Reset = 1'b0;
        #1;
        chk("async_reset", 4'd0, O_GREEN);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        cyc = 0;
        boat_req = 1'b1;

        // boat leaves during YELLOW: sequence still lifts, OPEN falls through to LOWER
        wait_to(33);  chk("yellow3", 4'd1, O_YELLOW);
        boat_req = 1'b0;
        wait_to(40);  chk("clear3_no_boat", 4'd2, O_CLEAR);
        wait_to(50);  chk("lift3_no_boat", 4'd4, O_LIFT);
        wait_to(52);  bridge_up = 1'b1;
        wait_to(53);  chk("open_no_boat", 4'd5, O_OPEN_NO);
        wait_to(54);  chk("lower_immediate", 4'd6, O_LOWER);
        bridge_down = 1'b1;
        wait_to(55);  chk("lower_conflict", 4'd8, O_FAULT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
